// File: rtl/uart_rx_if.sv
// Output bundle of uart_rx toward the seven-segment control stage.
// Handshake: uart_data is qualified by a one-cycle uart_data_valid pulse; there is no ready (the line cannot be stalled).
interface uart_rx_if;
   logic [7:0] uart_data;
   logic       uart_data_valid;
   logic       frame_error;
   logic       parity_error;
   logic [2:0] fsm_state;

   modport master (output uart_data, uart_data_valid, frame_error, parity_error, fsm_state);
   modport slave  (input  uart_data, uart_data_valid, frame_error, parity_error, fsm_state);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling off a free-running bit counter.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
`ifdef UART_PARITY_EN
   , parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic      clk,
   input  logic      resetn,
   input  logic      rx,
   uart_rx_if.master bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} state_t;

   state_t           state, state_n;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shreg, shreg_n;
   logic             armed, armed_n;
   logic             valid_n, ferr_n;
   logic [7:0]       data_q;
   logic             valid_q, ferr_q;
`ifdef UART_PARITY_EN
   logic             par_bad, par_bad_n;
   logic             perr_n, perr_q;
`endif

   // armed drops after a frame error so a held-low break yields one error only.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt + 1'b1;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      armed_n   = armed;
      valid_n   = 1'b0;
      ferr_n    = 1'b0;
`ifdef UART_PARITY_EN
      par_bad_n = par_bad;
      perr_n    = 1'b0;
`endif
      case (state)
         IDLE: begin
            bit_cnt_n = '0;
            if (rx_s) armed_n = 1'b1;
            else if (armed) state_n = START;
         end
         START: begin
            if (bit_cnt == HALF_CNT) begin
               bit_cnt_n = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_cnt == LAST_CNT) begin
               bit_cnt_n = '0;
               shreg_n   = {rx_s, shreg[7:1]};
               bit_idx_n = bit_idx + 1'b1;
               if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (bit_cnt == LAST_CNT) begin
               bit_cnt_n = '0;
               par_bad_n = (rx_s != (^shreg ^ PARITY_ODD));
               state_n   = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_cnt == LAST_CNT) begin
               bit_cnt_n = '0;
               state_n   = IDLE;
               if (!rx_s) begin
                  ferr_n  = 1'b1;
                  armed_n = 1'b0;
               end
`ifdef UART_PARITY_EN
               else if (par_bad) perr_n = 1'b1;
`endif
               else valid_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         armed   <= 1'b1;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
         par_bad <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         armed   <= armed_n;
         valid_q <= valid_n;
         ferr_q  <= ferr_n;
         if (valid_n) data_q <= shreg;
`ifdef UART_PARITY_EN
         par_bad <= par_bad_n;
         perr_q  <= perr_n;
`endif
      end
   end

   assign bus.uart_data       = data_q;
   assign bus.uart_data_valid = valid_q;
   assign bus.frame_error     = ferr_q;
   assign bus.fsm_state       = state;
`ifdef UART_PARITY_EN
   assign bus.parity_error    = perr_q;
`else
   assign bus.parity_error    = 1'b0;
`endif
endmodule
